datapath: RTL and testbench
===========================

# datapath

Single-bus 32-bit datapath for the Mini SRC CPU. Sixteen general-purpose registers, PC, IR, Y, 64-bit Z, HI, LO, MAR and MDR are joined by one combinational 32-bit bus, with an ALU between Y/bus and Z. An external control unit, or a bench, sequences it cycle by cycle through register enables, a bus-source select and an ALU opcode.

## Interface
- No parameters; data width is fixed at 32 bits.
- clock  in  1  single system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- incPC  in  1  forces the ALU result to bus+1 (PC increment path).
- GP_addr  in  4  general-purpose register written when e_GP=1.
- Mdatain  in  32  memory read data.
- MDR_read  in  1  MDR input mux: 1 selects Mdatain, 0 selects the bus.
- e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP  in  1 each  load enables.
- ALU_op  in  4  ALU operation.
- BusDataSelect  in  5  bus source.
- BusMuxOut  out  32  current bus value (observability).
- IR_out, MAR_out  out  32 each  IR and MAR contents.

## Operation
- Bus sources by BusDataSelect:
  - 0–15 → R0–R15
  - 16 → HI
  - 17 → LO
  - 18 → Zhigh
  - 19 → Zlow
  - 20 → PC
  - 21 → MDR
  - 22–31 → 32'h0
- Register loads (each on a rising edge with its enable high):
  - PC, IR, Y, HI, LO, MAR: load the bus.
  - R[GP_addr]: loads the bus when e_GP=1. R0 is an ordinary register.
  - MDR: loads (MDR_read ? Mdatain : bus).
- ALU operands: A = Y, B = bus. Z loads the 64-bit result {Zhigh, Zlow} when e_Z=1.
- ALU_op encoding (Zhigh = 0 unless stated):
  - 0000 ADD, 0001 SUB.
  - 0010 MUL: signed 64-bit product.
  - 0011 DIV: signed; Zlow = quotient, Zhigh = remainder. Divisor 0 gives Z = 0.
  - 0100 AND, 0101 OR.
  - 0110 SHR (logical), 0111 SHRA (arithmetic), 1000 SHL.
  - 1001 ROL, 1010 ROR.
  - 1011 NEG: Zlow = −B. 1100 NOT: Zlow = ~B.
  - 1101–1111: Z = 0.
- Shift and rotate amount = B[4:0]; amount 0 passes A unchanged.
- incPC=1 overrides ALU_op: result = {32'h0, B+1}. Zlow wraps 32'hFFFFFFFF → 0.
- ADD/SUB/NEG wrap modulo 2^32. No flags are produced.

## Timing
- The bus and ALU are purely combinational from the current register state and select inputs.
- All registers update on the rising clock edge. Several enables may be high in one cycle; every enabled register loads the same pre-edge bus value.
- Read-then-write of the same register in one cycle returns the old value.
- clear low asynchronously zeroes every register, including R0–R15 and Z. While clear is low all register outputs, and hence BusMuxOut for any select, read 0.
- Deasserting clear mid-sequence resumes normal loading at the next edge.
- Latency of an ALU operation:
  - cycle n: operand to Y.
  - cycle n+1: second operand on the bus; Z loads.
  - cycle n+2: Zlow visible on the bus.

## Structure
- Package datapath_pkg holds the ALU_op and BusDataSelect localparams.
- One sub-module, alu: combinational; inputs A, B, op, incPC; 64-bit output.
- Registers and the bus mux live in datapath.

## Test plan
- ROL sequence:
  - MDR←Mdatain 32'hA5A5A5A5 → R3.
  - 32'h7 → R7.
  - R3→Y, then R7 on bus with ALU_op 1001 → Z.
  - Zlow→R4.
  - Required: R4 = 32'hD2D2D2D2.
- Fetch: PC=0, select 20 with e_MAR, incPC, e_Z; next cycle select 19 with e_PC, and MDR_read loading 32'h2A338000; then select 21 with e_IR. Required: MAR=0, PC=1, IR_out=32'h2A338000.
- MUL: Y=32'hFFFFFFFE, bus=3 → Zhigh = 32'hFFFFFFFF, Zlow = 32'hFFFFFFFA. DIV: 17/5 → Zlow = 3, Zhigh = 2. DIV 5/0 → Z = 0.
- Shifts: SHRA on 32'h80000000 by 4 → 32'hF8000000. ROR on 32'h1 by 1 → 32'h80000000. Shift by 0 → unchanged.
- Reset: load R5 = 32'h1234, pull clear low between edges → R5, PC and Z read 0 immediately, before the next edge.
- Simultaneous loads: MDR on bus with e_Y, e_HI and e_LO all high → all three registers equal MDR. Select 25 → bus = 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the Mini SRC single-bus datapath: widths, ALU opcodes
// and bus-source select codes.
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_GP = 16;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_SHR  = 4'b0110;
    localparam logic [3:0] ALU_SHRA = 4'b0111;
    localparam logic [3:0] ALU_SHL  = 4'b1000;
    localparam logic [3:0] ALU_ROL  = 4'b1001;
    localparam logic [3:0] ALU_ROR  = 4'b1010;
    localparam logic [3:0] ALU_NEG  = 4'b1011;
    localparam logic [3:0] ALU_NOT  = 4'b1100;

    localparam logic [4:0] SEL_HI  = 5'd16;
    localparam logic [4:0] SEL_LO  = 5'd17;
    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_PC  = 5'd20;
    localparam logic [4:0] SEL_MDR = 5'd21;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; produces the 64-bit value
// that Z captures ({Zhigh, Zlow}).
module alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [3:0]          op,
    input  logic                inc_pc,
    output logic [2*DATA_W-1:0] result
);

    logic [4:0]          amt_s;
    logic signed [63:0]  a_wide_s;
    logic signed [63:0]  b_wide_s;
    logic signed [63:0]  prod_s;
    logic signed [32:0]  a_ext_s;
    logic signed [32:0]  b_ext_s;
    logic signed [32:0]  quo_s;
    logic signed [32:0]  rem_s;
    logic [DATA_W-1:0]   rol_s;
    logic [DATA_W-1:0]   ror_s;
    logic [DATA_W-1:0]   shra_s;

    assign amt_s    = b[4:0];
    assign a_wide_s = {{32{a[31]}}, a};
    assign b_wide_s = {{32{b[31]}}, b};
    assign prod_s   = a_wide_s * b_wide_s;
    // 33-bit operands so that -2^31 / -1 stays representable before truncation
    assign a_ext_s  = {a[31], a};
    assign b_ext_s  = {b[31], b};

    // Division path with the zero-divisor guard folded in
    always_comb begin
        quo_s = 33'sd0;
        rem_s = 33'sd0;
        if (b != 32'h0) begin
            quo_s = a_ext_s / b_ext_s;
            rem_s = a_ext_s % b_ext_s;
        end else begin
            quo_s = 33'sd0;
            rem_s = 33'sd0;
        end
    end

    // Shift and rotate results from the 5-bit amount in B
    always_comb begin
        rol_s  = 32'(({a, a} << amt_s) >> 32);
        ror_s  = 32'({a, a} >> amt_s);
        shra_s = $unsigned($signed(a) >>> amt_s);
    end

    // Result select; the PC-increment path overrides the opcode
    always_comb begin
        result = 64'h0;
        if (inc_pc) begin
            result = {32'h0, b + 32'd1};
        end else begin
            case (op)
                ALU_ADD:  result = {32'h0, a + b};
                ALU_SUB:  result = {32'h0, a - b};
                ALU_MUL:  result = $unsigned(prod_s);
                ALU_DIV:  result = {32'(rem_s), 32'(quo_s)};
                ALU_AND:  result = {32'h0, a & b};
                ALU_OR:   result = {32'h0, a | b};
                ALU_SHR:  result = {32'h0, a >> amt_s};
                ALU_SHRA: result = {32'h0, shra_s};
                ALU_SHL:  result = {32'h0, a << amt_s};
                ALU_ROL:  result = {32'h0, rol_s};
                ALU_ROR:  result = {32'h0, ror_s};
                ALU_NEG:  result = {32'h0, 32'h0 - b};
                ALU_NOT:  result = {32'h0, ~b};
                default:  result = 64'h0;
            endcase
        end
    end

endmodule

// File: rtl/datapath.sv
// Mini SRC single-bus datapath: register file, special registers, bus mux and
// ALU, sequenced externally through per-register load enables.
module datapath
    import datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              incPC,
    input  logic [3:0]        GP_addr,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic              MDR_read,
    input  logic              e_PC,
    input  logic              e_IR,
    input  logic              e_Y,
    input  logic              e_Z,
    input  logic              e_HI,
    input  logic              e_LO,
    input  logic              e_MDR,
    input  logic              e_MAR,
    input  logic              e_GP,
    input  logic [3:0]        ALU_op,
    input  logic [4:0]        BusDataSelect,
    output logic [DATA_W-1:0] BusMuxOut,
    output logic [DATA_W-1:0] IR_out,
    output logic [DATA_W-1:0] MAR_out
);

    logic [DATA_W-1:0]   gp_q [NUM_GP];
    logic [DATA_W-1:0]   gp_d [NUM_GP];
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]   bus_s;
    logic [2*DATA_W-1:0] alu_s;

    alu u_alu (
        .a      (y_q),
        .b      (bus_s),
        .op     (ALU_op),
        .inc_pc (incPC),
        .result (alu_s)
    );

    // Bus source mux; codes above the MDR select drive zero
    always_comb begin
        bus_s = 32'h0;
        if (BusDataSelect[4] == 1'b0) begin
            bus_s = gp_q[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect)
                SEL_HI:  bus_s = hi_q;
                SEL_LO:  bus_s = lo_q;
                SEL_ZHI: bus_s = z_q[63:32];
                SEL_ZLO: bus_s = z_q[31:0];
                SEL_PC:  bus_s = pc_q;
                SEL_MDR: bus_s = mdr_q;
                default: bus_s = 32'h0;
            endcase
        end
    end

    // Next-state: every enabled register captures the same pre-edge bus value
    always_comb begin
        pc_d  = e_PC  ? bus_s : pc_q;
        ir_d  = e_IR  ? bus_s : ir_q;
        y_d   = e_Y   ? bus_s : y_q;
        hi_d  = e_HI  ? bus_s : hi_q;
        lo_d  = e_LO  ? bus_s : lo_q;
        mar_d = e_MAR ? bus_s : mar_q;
        mdr_d = e_MDR ? (MDR_read ? Mdatain : bus_s) : mdr_q;
        z_d   = e_Z   ? alu_s : z_q;
        for (int i = 0; i < NUM_GP; i++) begin
            gp_d[i] = (e_GP && (GP_addr == 4'(i))) ? bus_s : gp_q[i];
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= 32'h0;
            ir_q  <= 32'h0;
            y_q   <= 32'h0;
            hi_q  <= 32'h0;
            lo_q  <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            z_q   <= 64'h0;
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= 32'h0;
            end
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            z_q   <= z_d;
            for (int i = 0; i < NUM_GP; i++) begin
                gp_q[i] <= gp_d[i];
            end
        end
    end

    assign BusMuxOut = bus_s;
    assign IR_out    = ir_q;
    assign MAR_out   = mar_q;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed test-plan sequences with literal
// expectations, then randomized control against an architectural model.
module tb_datapath;
    import datapath_pkg::*;

    logic        clock;
    logic        clear;
    logic        incPC;
    logic [3:0]  GP_addr;
    logic [31:0] Mdatain;
    logic        MDR_read;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP;
    logic [3:0]  ALU_op;
    logic [4:0]  BusDataSelect;
    logic [31:0] BusMuxOut, IR_out, MAR_out;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    datapath dut (
        .clock(clock), .clear(clear), .incPC(incPC), .GP_addr(GP_addr),
        .Mdatain(Mdatain), .MDR_read(MDR_read),
        .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI),
        .e_LO(e_LO), .e_MDR(e_MDR), .e_MAR(e_MAR), .e_GP(e_GP),
        .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
        .BusMuxOut(BusMuxOut), .IR_out(IR_out), .MAR_out(MAR_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_y, m_hi, m_lo, m_mar, m_mdr;
    logic [63:0] m_z;
    logic [31:0] m_bus;
    logic [63:0] m_alu_out;

    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic inc);
        longint sa, sb, q, r;
        logic [31:0] t;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        t  = a;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            4'd0:  return {32'h0, a + b};
            4'd1:  return {32'h0, a - b};
            4'd2:  return 64'(sa * sb);
            4'd3: begin
                if (b == 32'h0) return 64'h0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4:  return {32'h0, a & b};
            4'd5:  return {32'h0, a | b};
            4'd6:  return {32'h0, a >> n};
            4'd7: begin
                repeat (n) t = {t[31], t[31:1]};
                return {32'h0, t};
            end
            4'd8:  return {32'h0, a << n};
            4'd9: begin
                repeat (n) t = {t[30:0], t[31]};
                return {32'h0, t};
            end
            4'd10: begin
                repeat (n) t = {t[0], t[31:1]};
                return {32'h0, t};
            end
            4'd11: return {32'h0, 32'h0 - b};
            4'd12: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    always_comb begin
        m_bus = 32'h0;
        if (BusDataSelect < 5'd16) begin
            m_bus = m_r[BusDataSelect[3:0]];
        end else begin
            case (BusDataSelect)
                5'd16:   m_bus = m_hi;
                5'd17:   m_bus = m_lo;
                5'd18:   m_bus = m_z[63:32];
                5'd19:   m_bus = m_z[31:0];
                5'd20:   m_bus = m_pc;
                5'd21:   m_bus = m_mdr;
                default: m_bus = 32'h0;
            endcase
        end
    end

    always_comb m_alu_out = m_alu(m_y, m_bus, ALU_op, incPC);

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) m_r[i] <= 32'h0;
            m_pc <= 32'h0; m_ir <= 32'h0; m_y <= 32'h0; m_hi <= 32'h0;
            m_lo <= 32'h0; m_mar <= 32'h0; m_mdr <= 32'h0; m_z <= 64'h0;
        end else begin
            if (e_GP)  m_r[GP_addr] <= m_bus;
            if (e_PC)  m_pc  <= m_bus;
            if (e_IR)  m_ir  <= m_bus;
            if (e_Y)   m_y   <= m_bus;
            if (e_HI)  m_hi  <= m_bus;
            if (e_LO)  m_lo  <= m_bus;
            if (e_MAR) m_mar <= m_bus;
            if (e_MDR) m_mdr <= MDR_read ? Mdatain : m_bus;
            if (e_Z)   m_z   <= m_alu_out;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clock) begin
        if (chk_on) begin
            chk("bus_vs_model", 64'(BusMuxOut), 64'(m_bus));
            chk("ir_vs_model",  64'(IR_out),    64'(m_ir));
            chk("mar_vs_model", 64'(MAR_out),   64'(m_mar));
        end
    end

    task automatic clr_ctl();
        {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP} = 9'h0;
        incPC = 1'b0; MDR_read = 1'b0; ALU_op = 4'd0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr_ctl();
    endtask

    task automatic peek(input logic [4:0] sel, input string name, input logic [31:0] exp);
        BusDataSelect = sel;
        #1;
        chk(name, 64'(BusMuxOut), 64'(exp));
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; MDR_read = 1'b1; e_MDR = 1'b1;
        tick();
    endtask

    task automatic load_gp(input logic [3:0] r, input logic [31:0] v);
        load_mdr(v);
        BusDataSelect = SEL_MDR; GP_addr = r; e_GP = 1'b1;
        tick();
    endtask

    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        load_mdr(a);
        BusDataSelect = SEL_MDR; e_Y = 1'b1;
        tick();
        load_mdr(b);
        BusDataSelect = SEL_MDR; ALU_op = op; e_Z = 1'b1;
        tick();
    endtask

    initial begin
        clr_ctl();
        clear = 1'b1; GP_addr = 4'd0; Mdatain = 32'h0; BusDataSelect = 5'd0;
        #2 clear = 1'b0;
        #10 clear = 1'b1;
        chk_on = 1'b1;
        @(posedge clock); #1;

        // Reset state
        chk("reset_ir", 64'(IR_out), 64'h0);
        chk("reset_mar", 64'(MAR_out), 64'h0);
        peek(SEL_PC, "reset_pc", 32'h0);
        peek(SEL_ZLO, "reset_zlo", 32'h0);

        // Instruction fetch
        BusDataSelect = SEL_PC; e_MAR = 1'b1; incPC = 1'b1; e_Z = 1'b1;
        tick();
        BusDataSelect = SEL_ZLO; e_PC = 1'b1;
        Mdatain = 32'h2A338000; MDR_read = 1'b1; e_MDR = 1'b1;
        tick();
        BusDataSelect = SEL_MDR; e_IR = 1'b1;
        tick();
        chk("fetch_mar", 64'(MAR_out), 64'h0);
        chk("fetch_ir", 64'(IR_out), 64'h2A338000);
        peek(SEL_PC, "fetch_pc", 32'h1);

        // ROL sequence through the register file
        load_gp(4'd3, 32'hA5A5A5A5);
        load_gp(4'd7, 32'h7);
        BusDataSelect = 5'd3; e_Y = 1'b1;
        tick();
        BusDataSelect = 5'd7; ALU_op = ALU_ROL; e_Z = 1'b1;
        tick();
        BusDataSelect = SEL_ZLO; GP_addr = 4'd4; e_GP = 1'b1;
        tick();
        peek(5'd4, "rol_r4", 32'hD2D2D2D2);

        alu_run(32'hFFFFFFFE, 32'd3, ALU_MUL);
        peek(SEL_ZHI, "mul_hi", 32'hFFFFFFFF);
        peek(SEL_ZLO, "mul_lo", 32'hFFFFFFFA);
        alu_run(32'd17, 32'd5, ALU_DIV);
        peek(SEL_ZLO, "div_quo", 32'd3);
        peek(SEL_ZHI, "div_rem", 32'd2);
        alu_run(32'd5, 32'd0, ALU_DIV);
        peek(SEL_ZLO, "div0_lo", 32'd0);
        peek(SEL_ZHI, "div0_hi", 32'd0);
        alu_run(32'h80000000, 32'd4, ALU_SHRA);
        peek(SEL_ZLO, "shra", 32'hF8000000);
        alu_run(32'h1, 32'd1, ALU_ROR);
        peek(SEL_ZLO, "ror", 32'h80000000);
        alu_run(32'h00001234, 32'd0, ALU_SHL);
        peek(SEL_ZLO, "shl0", 32'h00001234);
        alu_run(32'h00001234, 32'd0, ALU_ROL);
        peek(SEL_ZLO, "rol0", 32'h00001234);
        alu_run(32'h0, 32'hFFFFFFFF, ALU_ADD);
        incPC = 1'b1; BusDataSelect = SEL_ZLO; e_Z = 1'b1;
        tick();
        peek(SEL_ZLO, "incpc_wrap", 32'h0);

        // Simultaneous loads from one bus value, and an unused select
        load_mdr(32'hCAFEBABE);
        BusDataSelect = SEL_MDR; e_Y = 1'b1; e_HI = 1'b1; e_LO = 1'b1;
        tick();
        peek(SEL_HI, "multi_hi", 32'hCAFEBABE);
        peek(SEL_LO, "multi_lo", 32'hCAFEBABE);
        peek(5'd25, "sel25_zero", 32'h0);
        ALU_op = ALU_ADD; e_Z = 1'b1;
        tick();
        peek(SEL_ZLO, "multi_y", 32'hCAFEBABE);

        // Asynchronous clear between edges
        load_gp(4'd5, 32'h1234);
        peek(5'd5, "r5_loaded", 32'h1234);
        clear = 1'b0;
        peek(5'd5, "clear_r5", 32'h0);
        peek(SEL_PC, "clear_pc", 32'h0);
        peek(SEL_ZLO, "clear_zlo", 32'h0);
        clear = 1'b1;
        tick();

        // Randomized control against the model
        for (int i = 0; i < 3000; i++) begin
            e_PC  = ($urandom_range(0, 7) == 0);
            e_IR  = ($urandom_range(0, 3) == 0);
            e_Y   = ($urandom_range(0, 2) == 0);
            e_Z   = ($urandom_range(0, 1) == 0);
            e_HI  = ($urandom_range(0, 3) == 0);
            e_LO  = ($urandom_range(0, 3) == 0);
            e_MDR = ($urandom_range(0, 2) == 0);
            e_MAR = ($urandom_range(0, 3) == 0);
            e_GP  = ($urandom_range(0, 1) == 0);
            incPC = ($urandom_range(0, 7) == 0);
            MDR_read = ($urandom_range(0, 1) == 0);
            GP_addr = 4'($urandom_range(0, 15));
            ALU_op = 4'($urandom_range(0, 15));
            BusDataSelect = 5'($urandom_range(0, 31));
            Mdatain = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #1 clear = 1'b0;
                #1 clear = 1'b1;
            end
            @(posedge clock); #1;
        end

        clr_ctl();
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
